// File: rtl/board_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : board_state_ctrl
//  Description : Game-state keeper for a 6x6 gomoku board. Moves a cursor,
//                places alternating black/white stones into empty cells and
//                tracks turn and stone count on a working copy. A display
//                copy (board, cursor_addr) is refreshed only on frame_start
//                so the pixel generator never sees a mid-frame change.
//  Ports       : clk, rst (async, active-high)
//                btn_up/down/left/right  cursor move pulses
//                btn_place / btn_new     place-stone / new-game pulses
//                frame_start             vertical-blanking pulse
//                board[36]               display copy (0 empty,1 black,2 white)
//                cursor_addr             display copy of cursor index 0..35
//                turn                    side to move (0 black, 1 white)
//                stone_cnt / board_full  working stone count, count == 36
//                place_reject            one-cycle refused-place pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module board_state_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_place,
  input  logic       btn_new,
  input  logic       frame_start,
  output logic [1:0] board [0:35],
  output logic [5:0] cursor_addr,
  output logic       turn,
  output logic [5:0] stone_cnt,
  output logic       board_full,
  output logic       place_reject
);

  localparam int         C_CELLS    = 36;
  localparam logic [5:0] C_FULL_CNT = 6'd36;
  localparam logic [5:0] C_HOME_IDX = 6'd14;
  localparam logic [2:0] C_HOME_RC  = 3'd2;
  localparam logic [2:0] C_MAX_RC   = 3'd5;

  logic [1:0] wboard_q   [0:C_CELLS-1];
  logic [1:0] wboard_d   [0:C_CELLS-1];
  logic [1:0] board_q    [0:C_CELLS-1];
  logic [1:0] board_d    [0:C_CELLS-1];
  logic [2:0] wrow_q, wrow_d;
  logic [2:0] wcol_q, wcol_d;
  logic       turn_q, turn_d;
  logic [5:0] stone_cnt_q, stone_cnt_d;
  logic       place_reject_q, place_reject_d;
  logic [5:0] cursor_addr_q, cursor_addr_d;

  logic [5:0] cur_idx;
  logic       cur_occupied;

  // Pre-edge cursor index; used both for placing and for the display snapshot.
  assign cur_idx      = ({3'b000, wrow_q} * 6'd6) + {3'b000, wcol_q};
  assign cur_occupied = (wboard_q[cur_idx] != 2'd0);

  always_comb begin
    wboard_d       = wboard_q;
    board_d        = board_q;
    wrow_d         = wrow_q;
    wcol_d         = wcol_q;
    turn_d         = turn_q;
    stone_cnt_d    = stone_cnt_q;
    place_reject_d = 1'b0;
    cursor_addr_d  = cursor_addr_q;

    if (btn_new) begin
      // New game overrides every other request issued in the same cycle.
      for (int i = 0; i < C_CELLS; i++) wboard_d[i] = 2'd0;
      wrow_d      = C_HOME_RC;
      wcol_d      = C_HOME_RC;
      turn_d      = 1'b0;
      stone_cnt_d = 6'd0;
    end else begin
      if (btn_place) begin
        // A full board always has the cursor cell occupied, so the occupancy
        // test alone also covers the full-board refusal.
        if (!cur_occupied && (stone_cnt_q != C_FULL_CNT)) begin
          wboard_d[cur_idx] = turn_q ? 2'd2 : 2'd1;
          turn_d            = ~turn_q;
          stone_cnt_d       = stone_cnt_q + 6'd1;
        end else begin
          place_reject_d = 1'b1;
        end
      end

      // Opposing presses cancel; moves saturate at the board edge.
      if (btn_up && !btn_down && (wrow_q != 3'd0))
        wrow_d = wrow_q - 3'd1;
      else if (btn_down && !btn_up && (wrow_q != C_MAX_RC))
        wrow_d = wrow_q + 3'd1;

      if (btn_left && !btn_right && (wcol_q != 3'd0))
        wcol_d = wcol_q - 3'd1;
      else if (btn_right && !btn_left && (wcol_q != C_MAX_RC))
        wcol_d = wcol_q + 3'd1;
    end

    // Snapshot the pre-edge working state; same-cycle edits show next frame.
    if (frame_start) begin
      board_d       = wboard_q;
      cursor_addr_d = cur_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < C_CELLS; i++) begin
        wboard_q[i] <= 2'd0;
        board_q[i]  <= 2'd0;
      end
      wrow_q         <= C_HOME_RC;
      wcol_q         <= C_HOME_RC;
      turn_q         <= 1'b0;
      stone_cnt_q    <= 6'd0;
      place_reject_q <= 1'b0;
      cursor_addr_q  <= C_HOME_IDX;
    end else begin
      wboard_q       <= wboard_d;
      board_q        <= board_d;
      wrow_q         <= wrow_d;
      wcol_q         <= wcol_d;
      turn_q         <= turn_d;
      stone_cnt_q    <= stone_cnt_d;
      place_reject_q <= place_reject_d;
      cursor_addr_q  <= cursor_addr_d;
    end
  end

  assign board        = board_q;
  assign cursor_addr  = cursor_addr_q;
  assign turn         = turn_q;
  assign stone_cnt    = stone_cnt_q;
  assign board_full   = (stone_cnt_q == C_FULL_CNT);
  assign place_reject = place_reject_q;

endmodule
`default_nettype wire

// File: tb/tb_board_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_state_ctrl
//  Description : Directed self-checking bench for board_state_ctrl. Inputs are
//                driven 1 time unit after a rising edge and outputs are
//                sampled 1 time unit after the following rising edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_state_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
  logic       btn_place = 1'b0, btn_new = 1'b0, frame_start = 1'b0;
  logic [1:0] board [0:35];
  logic [5:0] cursor_addr;
  logic       turn;
  logic [5:0] stone_cnt;
  logic       board_full;
  logic       place_reject;

  int total = 0;
  int bad   = 0;
  int exp_b [0:35];

  board_state_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .btn_up       (btn_up),
    .btn_down     (btn_down),
    .btn_left     (btn_left),
    .btn_right    (btn_right),
    .btn_place    (btn_place),
    .btn_new      (btn_new),
    .frame_start  (frame_start),
    .board        (board),
    .cursor_addr  (cursor_addr),
    .turn         (turn),
    .stone_cnt    (stone_cnt),
    .board_full   (board_full),
    .place_reject (place_reject)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Apply one cycle of pulses, then land 1 unit after the capturing edge.
  task automatic cyc(input logic u, input logic d, input logic l, input logic r,
                     input logic p, input logic n, input logic f);
    btn_up = u; btn_down = d; btn_left = l; btn_right = r;
    btn_place = p; btn_new = n; frame_start = f;
    @(posedge clk);
    #1;
    btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    btn_place = 0; btn_new = 0; frame_start = 0;
  endtask

  function automatic int nonzero_cells();
    int n = 0;
    for (int i = 0; i < 36; i++) if (board[i] != 2'd0) n++;
    return n;
  endfunction

  initial begin
    // ---------------- reset ----------------
    @(posedge clk); @(posedge clk); #1;
    chk("rst_nonzero", nonzero_cells(), 0);
    chk("rst_cursor", int'(cursor_addr), 14);
    chk("rst_turn", int'(turn), 0);
    chk("rst_cnt", int'(stone_cnt), 0);
    chk("rst_full", int'(board_full), 0);
    chk("rst_reject", int'(place_reject), 0);
    rst = 1'b0;

    cyc(0,0,0,0,0,0,1);
    chk("f0_nonzero", nonzero_cells(), 0);
    chk("f0_cursor", int'(cursor_addr), 14);

    // ---------------- first place ----------------
    cyc(0,0,0,0,1,0,0);
    chk("p1_turn", int'(turn), 1);
    chk("p1_cnt", int'(stone_cnt), 1);
    chk("p1_reject", int'(place_reject), 0);
    chk("p1_nodisp", int'(board[14]), 0);
    cyc(0,0,0,0,0,0,1);
    chk("p1_disp14", int'(board[14]), 1);

    // ---------------- occupied reject ----------------
    cyc(0,0,0,0,1,0,0);
    chk("rej_pulse", int'(place_reject), 1);
    chk("rej_cnt", int'(stone_cnt), 1);
    chk("rej_turn", int'(turn), 1);
    cyc(0,0,0,0,0,0,0);
    chk("rej_once", int'(place_reject), 0);

    // ---------------- cursor saturation / cancel / diagonal ----------------
    for (int i = 0; i < 4; i++) cyc(1,0,0,0,0,0,0);
    for (int i = 0; i < 4; i++) cyc(0,0,1,0,0,0,0);
    cyc(0,0,0,0,0,0,1);
    chk("sat_cursor", int'(cursor_addr), 0);
    cyc(1,1,1,1,0,0,0);                 // both axes cancel
    cyc(0,0,0,0,0,0,1);
    chk("cancel_cursor", int'(cursor_addr), 0);
    cyc(0,1,0,1,0,0,0);                 // (0,0) -> (1,1)
    cyc(0,0,0,0,0,0,1);
    chk("diag_dr", int'(cursor_addr), 7);
    cyc(1,0,0,1,0,0,0);                 // (1,1) -> (0,2)
    cyc(0,0,0,0,0,0,1);
    chk("diag_ur", int'(cursor_addr), 2);

    // ---------------- display double buffering ----------------
    cyc(0,0,0,0,1,0,0);                 // white at 2
    chk("p2_cnt", int'(stone_cnt), 2);
    chk("p2_turn", int'(turn), 0);
    cyc(0,0,0,0,0,0,0);
    chk("p2_nodisp", int'(board[2]), 0);
    cyc(0,0,0,1,0,0,0);                 // cursor 3
    cyc(0,0,0,0,1,0,1);                 // black at 3 together with frame
    chk("pf_disp2", int'(board[2]), 2);
    chk("pf_disp3", int'(board[3]), 0);
    chk("pf_cursor", int'(cursor_addr), 3);
    cyc(0,0,0,0,0,0,1);
    chk("pf_disp3_next", int'(board[3]), 1);

    // ---------------- place + move same cycle ----------------
    cyc(0,0,0,1,0,0,0);                 // cursor 4
    cyc(0,0,0,1,1,0,0);                 // white at 4, cursor 5
    cyc(0,0,0,0,0,0,1);
    chk("pm_disp4", int'(board[4]), 2);
    chk("pm_cursor", int'(cursor_addr), 5);
    chk("pm_cnt", int'(stone_cnt), 4);

    // ---------------- back-to-back place ----------------
    cyc(0,0,0,0,1,0,0);
    chk("bb_first_rej", int'(place_reject), 0);
    cyc(0,0,0,0,1,0,0);
    chk("bb_second_rej", int'(place_reject), 1);
    chk("bb_cnt", int'(stone_cnt), 5);
    chk("bb_turn", int'(turn), 1);

    // ---------------- new game overrides place ----------------
    cyc(0,0,0,0,1,1,0);
    chk("ng_cnt", int'(stone_cnt), 0);
    chk("ng_turn", int'(turn), 0);
    chk("ng_reject", int'(place_reject), 0);
    cyc(0,0,0,0,0,0,1);
    chk("ng_nonzero", nonzero_cells(), 0);
    chk("ng_cursor", int'(cursor_addr), 14);

    // ---------------- fill whole board (serpentine) ----------------
    cyc(1,0,1,0,0,0,0);
    cyc(1,0,1,0,0,0,0);                 // cursor 0
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < 6; c++) begin
        int col;
        col = (r % 2 == 0) ? c : 5 - c;
        exp_b[r*6 + col] = ((r*6 + c) % 2 == 0) ? 1 : 2;
        if (c < 5) begin
          if (r % 2 == 0) cyc(0,0,0,1,1,0,0);
          else            cyc(0,0,1,0,1,0,0);
        end else if (r < 5) begin
          cyc(0,1,0,0,1,0,0);
        end else begin
          cyc(0,0,0,0,1,0,0);
        end
      end
    end
    chk("fill_cnt", int'(stone_cnt), 36);
    chk("fill_full", int'(board_full), 1);
    chk("fill_turn", int'(turn), 0);
    cyc(0,0,0,0,0,0,1);
    for (int i = 0; i < 36; i++) chk($sformatf("fill_cell%0d", i), int'(board[i]), exp_b[i]);
    cyc(0,0,0,0,1,0,0);
    chk("full_reject", int'(place_reject), 1);
    chk("full_cnt", int'(stone_cnt), 36);

    // ---------------- async reset mid-frame ----------------
    rst = 1'b1;
    #2;
    chk("arst_nonzero", nonzero_cells(), 0);
    chk("arst_cursor", int'(cursor_addr), 14);
    chk("arst_cnt", int'(stone_cnt), 0);
    chk("arst_full", int'(board_full), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc(0,0,0,0,0,0,0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
